p_cache_dm: RTL and testbench

//  Parametrised direct-mapped program cache; next generation of the fixed 16-bit/512-line program cache.

---
 rtl/p_cache_dm.sv | 149 ++++++++++++++
 tb/tb_p_cache_dm.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/p_cache_dm.sv
// Direct-mapped program cache between the CPU fetch port and a line-wide memory port.
// Per-line valid bits, flush support and a saturating miss counter.
module p_cache_dm #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned WSEL_W  = 2,
    parameter int unsigned INDEX_W = 9
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ADDR_W-1:0]                   CPU_address,
    output logic [DATA_W-1:0]                   CPU_data,
    output logic                                p_cache_miss,
    input  logic                                flush,
    output logic [ADDR_W-WSEL_W-1:0]            mem_address,
    input  logic [(DATA_W<<WSEL_W)-1:0]         mem_data,
    output logic                                mem_req,
    input  logic                                mem_ready,
    output logic [15:0]                         miss_count,
    output logic                                p_fetch_active
);

    localparam int unsigned LINE_W  = DATA_W << WSEL_W;
    localparam int unsigned TAG_W   = ADDR_W - INDEX_W - WSEL_W;
    localparam int unsigned LADDR_W = ADDR_W - WSEL_W;
    localparam int unsigned LINES   = 1 << INDEX_W;
    localparam int unsigned WORDS   = 1 << WSEL_W;
    localparam int unsigned ENTRY_W = TAG_W + LINE_W;

    typedef enum logic [1:0] {StIdle, StFetch, StRetry} state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q;
    logic [LADDR_W-1:0]   miss_line_q, miss_line_d;
    logic [15:0]          miss_count_q, miss_count_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 flush_dly_q, flush_dly_d;
    logic [LINES-1:0]     valid_q, valid_d;

    logic [ENTRY_W-1:0]   ram [LINES];
    logic [ENTRY_W-1:0]   ram_rdata_q;
    logic [ENTRY_W-1:0]   ram_wdata;
    logic [INDEX_W-1:0]   ram_idx;
    logic                 ram_we;

    logic [INDEX_W-1:0]   cur_idx;
    logic [TAG_W-1:0]     cur_tag;
    logic [TAG_W-1:0]     rd_tag;
    logic [INDEX_W-1:0]   miss_idx;
    logic [DATA_W-1:0]    rd_words [WORDS];
    logic                 hit;

    assign cur_idx  = addr_q[WSEL_W +: INDEX_W];
    assign cur_tag  = addr_q[ADDR_W-1 -: TAG_W];
    assign rd_tag   = ram_rdata_q[ENTRY_W-1 -: TAG_W];
    assign miss_idx = miss_line_q[INDEX_W-1:0];

    for (genvar w = 0; w < WORDS; w++) begin : g_words
        assign rd_words[w] = ram_rdata_q[w*DATA_W +: DATA_W];
    end

    assign hit = valid_q[cur_idx] & (rd_tag == cur_tag) & (state_q == StIdle) & ~flush_dly_q;

    assign CPU_data       = rd_words[addr_q[WSEL_W-1:0]];
    assign p_cache_miss   = ~hit;
    assign mem_address    = miss_line_q;
    assign mem_req        = (state_q == StFetch) & ~mem_ready;
    assign miss_count     = miss_count_q;
    assign p_fetch_active = (state_q == StFetch);
    assign ram_wdata      = {miss_line_q[LADDR_W-1 -: TAG_W], mem_data};

    always_comb begin
        state_d      = state_q;
        miss_line_d  = miss_line_q;
        miss_count_d = miss_count_q;
        flush_pend_d = flush_pend_q;
        flush_dly_d  = 1'b0;
        valid_d      = valid_q;
        ram_we       = 1'b0;
        ram_idx      = CPU_address[WSEL_W +: INDEX_W];
        unique case (state_q)
            StIdle: begin
                if (flush) begin
                    valid_d     = '0;
                    flush_dly_d = 1'b1;
                end
                if (!hit && !flush_dly_q) begin
                    state_d     = StFetch;
                    miss_line_d = addr_q[ADDR_W-1:WSEL_W];
                    if (miss_count_q != 16'hFFFF) begin
                        miss_count_d = miss_count_q + 16'd1;
                    end
                end
            end
            StFetch: begin
                ram_idx = miss_idx;
                if (mem_ready) begin
                    ram_we  = 1'b1;
                    state_d = StRetry;
                    // A flush seen during the fill leaves the fresh line invalid.
                    if (flush_pend_q || flush) begin
                        valid_d      = '0;
                        flush_pend_d = 1'b0;
                    end else begin
                        valid_d[miss_idx] = 1'b1;
                    end
                end else if (flush) begin
                    flush_pend_d = 1'b1;
                end
            end
            StRetry: begin
                if (flush) begin
                    valid_d     = '0;
                    flush_dly_d = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            miss_line_q  <= '0;
            miss_count_q <= '0;
            flush_pend_q <= 1'b0;
            flush_dly_q  <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= CPU_address;
            miss_line_q  <= miss_line_d;
            miss_count_q <= miss_count_d;
            flush_pend_q <= flush_pend_d;
            flush_dly_q  <= flush_dly_d;
            valid_q      <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= ram_wdata;
        end
        ram_rdata_q <= ram[ram_idx];
    end

endmodule

// File: tb/tb_p_cache_dm.sv
// Directed bench for p_cache_dm: cold fill, word select, conflicts, flushes, reset mid-fetch.
module tb_p_cache_dm;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] CPU_address;
    logic [15:0] CPU_data;
    logic        p_cache_miss;
    logic        flush;
    logic [13:0] mem_address;
    logic [63:0] mem_data;
    logic        mem_req;
    logic        mem_ready;
    logic [15:0] miss_count;
    logic        p_fetch_active;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] LineA = 64'h4444_3333_2222_1111;
    localparam logic [63:0] LineB = 64'h8888_7777_6666_5555;
    localparam logic [63:0] LineX = 64'hDEAD_BEEF_CAFE_F00D;

    p_cache_dm #(
        .ADDR_W (16),
        .DATA_W (16),
        .WSEL_W (2),
        .INDEX_W(9)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .CPU_address   (CPU_address),
        .CPU_data      (CPU_data),
        .p_cache_miss  (p_cache_miss),
        .flush         (flush),
        .mem_address   (mem_address),
        .mem_data      (mem_data),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .miss_count    (miss_count),
        .p_fetch_active(p_fetch_active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One fill: mem_ready for a cycle, RETRY, then back in IDLE.
    task automatic serve(input logic [63:0] line);
        mem_ready = 1'b1;
        mem_data  = line;
        tick();
        mem_ready = 1'b0;
        check("retry_miss", p_cache_miss, 1);
        tick();
    endtask

    initial begin
        rst = 1'b1; CPU_address = 16'h0000; flush = 1'b0; mem_ready = 1'b0; mem_data = '0;
        tick();
        tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_address, 14'h0000);
        check("rst_miss", p_cache_miss, 1);
        check("rst_count", miss_count, 0);
        check("rst_fetch", p_fetch_active, 0);

        // Cold miss on 0x0000
        rst = 1'b0;
        tick();
        check("cold_miss", p_cache_miss, 1);
        check("cold_req", mem_req, 1);
        check("cold_addr", mem_address, 14'h0000);
        check("cold_count", miss_count, 1);
        repeat (4) tick();
        check("cold_wait_req", mem_req, 1);
        mem_ready = 1'b1;
        mem_data  = LineA;
        #1;
        check("req_drop_on_ready", mem_req, 0);
        tick();
        mem_ready = 1'b0;
        check("cold_retry_miss", p_cache_miss, 1);
        tick();
        check("cold_hit", p_cache_miss, 0);
        check("cold_data", CPU_data, 16'h1111);

        // Word select
        CPU_address = 16'h0001; tick();
        check("w1_miss", p_cache_miss, 0);
        check("w1_data", CPU_data, 16'h2222);
        CPU_address = 16'h0002; tick();
        check("w2_data", CPU_data, 16'h3333);
        CPU_address = 16'h0003; tick();
        check("w3_data", CPU_data, 16'h4444);
        check("w3_miss", p_cache_miss, 0);
        check("w_count", miss_count, 1);

        // Conflict: same index, tag 1
        CPU_address = 16'h0800; tick();
        check("conf_miss", p_cache_miss, 1);
        check("conf_idle_req", mem_req, 0);
        tick();
        check("conf_addr", mem_address, 14'h0200);
        check("conf_count", miss_count, 2);
        serve(LineB);
        check("conf_hit", p_cache_miss, 0);
        check("conf_data", CPU_data, 16'h5555);

        CPU_address = 16'h0000; tick();
        check("back_miss", p_cache_miss, 1);
        tick();
        check("back_count", miss_count, 3);
        check("back_addr", mem_address, 14'h0000);
        serve(LineA);
        check("back_data", CPU_data, 16'h1111);

        // Flush while hitting in IDLE
        flush = 1'b1; tick(); flush = 1'b0;
        check("fl_idle_miss", p_cache_miss, 1);
        check("fl_idle_nofetch", p_fetch_active, 0);
        tick();
        check("fl_idle_miss2", p_cache_miss, 1);
        check("fl_idle_nofetch2", p_fetch_active, 0);
        tick();
        check("fl_idle_fetch", p_fetch_active, 1);
        check("fl_idle_count", miss_count, 4);

        // Flush two cycles before mem_ready
        flush = 1'b1; tick(); flush = 1'b0;
        tick();
        serve(LineA);
        check("fl_fetch_miss", p_cache_miss, 1);
        tick();
        check("fl_fetch_refetch", p_fetch_active, 1);
        check("fl_fetch_count", miss_count, 5);
        check("fl_fetch_addr", mem_address, 14'h0000);
        serve(LineA);
        check("fl_fetch_hit", p_cache_miss, 0);
        check("fl_fetch_data", CPU_data, 16'h1111);

        // mem_ready outside FETCH must not write
        mem_ready = 1'b1; mem_data = LineX; tick(); mem_ready = 1'b0;
        check("stray_ready_state", p_fetch_active, 0);
        check("stray_ready_hit", p_cache_miss, 0);
        tick();
        check("stray_ready_data", CPU_data, 16'h1111);

        // Reset mid-FETCH
        CPU_address = 16'h0800; tick(); tick();
        check("rf_req", mem_req, 1);
        check("rf_count", miss_count, 6);
        rst = 1'b1; #1;
        check("rf_req_async", mem_req, 0);
        check("rf_count_clr", miss_count, 0);
        tick();
        mem_ready = 1'b1; mem_data = LineX; tick(); mem_ready = 1'b0;
        check("rf_ready_ignored", p_fetch_active, 0);
        check("rf_ready_req", mem_req, 0);
        rst = 1'b0;
        tick();
        check("rf_restart_fetch", p_fetch_active, 1);
        check("rf_restart_count", miss_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
